inert_spi_seq: RTL and testbench

Sequencer that owns the single SPI master (SPI_mnrch) talking to the iNEMO inertial sensor.
- After reset it waits a power-up interval, then writes the three sensor configuration registers.
- After that, every data-ready interrupt (INT) triggers a two-transaction read of yaw-rate low/high bytes.
- It delivers a 16-bit yaw-rate sample with a one-cycle valid to the integrator downstream.

---
 rtl/inert_pkg.sv | 36 +++
 rtl/inert_spi_seq.sv | 170 +++++++++++++++++
 tb/tb_inert_spi_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inert_pkg.sv
// Shared definitions for the iNEMO yaw-rate SPI sequencer: state encoding,
// sensor configuration words and read commands.
package inert_pkg;

  typedef enum logic [2:0] {
    INIT_WAIT = 3'd0,
    CFG_ISSUE = 3'd1,
    CFG_WAIT  = 3'd2,
    IDLE      = 3'd3,
    RDL_ISSUE = 3'd4,
    RDL_WAIT  = 3'd5,
    RDH_ISSUE = 3'd6,
    RDH_WAIT  = 3'd7
  } state_e;

  // Configuration writes, issued once after power-up in index order
  localparam logic [15:0] CFG_INT  = 16'h0D02;  // INT on gyro data-ready
  localparam logic [15:0] CFG_GYRO = 16'h1160;  // gyro ODR 416 Hz
  localparam logic [15:0] CFG_CTRL = 16'h1440;  // rounding enable

  // Yaw-rate register reads
  localparam logic [15:0] RD_YAWL = 16'hA600;
  localparam logic [15:0] RD_YAWH = 16'hA700;

  // Configuration word for a given table index
  function automatic logic [15:0] cfg_word(input logic [1:0] idx);
    logic [15:0] w;
    case (idx)
      2'd0:    w = CFG_INT;
      2'd1:    w = CFG_GYRO;
      default: w = CFG_CTRL;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/inert_spi_seq.sv
// Sequencer owning the SPI master to the iNEMO sensor: waits out power-up,
// writes three configuration registers, then on each data-ready interrupt
// reads the yaw-rate low/high bytes and presents a 16-bit sample with a
// one-cycle valid. Stalled transactions are retried and flagged in err.
module inert_spi_seq
  import inert_pkg::*;
#(
  parameter int TMR_W  = 16,
  parameter int TO_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        setup_done,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        err
);

  localparam int TO_W = $clog2(TO_CYC + 1);

  state_e            state_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [TMR_W-1:0]  tmr_d;
  logic [TO_W-1:0]   to_cnt_q;
  logic [TO_W-1:0]   to_cnt_d;
  logic              to_expired_s;
  logic [1:0]        idx_q;
  logic [7:0]        low_q;
  logic              int_ff1_q;
  logic              int_ff2_q;
  logic              wrt_q;
  logic [15:0]       cmd_q;
  logic              setup_done_q;
  logic [15:0]       yaw_q;
  logic              vld_q;
  logic              err_q;
  logic              rd_hi_unused_s;

  // Only the low byte of each SPI read carries sensor data
  assign rd_hi_unused_s = ^rd_data[15:8];

  assign tmr_d        = tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
  assign to_cnt_d     = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
  assign to_expired_s = (to_cnt_q == TO_W'(TO_CYC - 1));

  // Two-flop synchronizer for the asynchronous data-ready interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      int_ff1_q <= 1'b0;
      int_ff2_q <= 1'b0;
    end else begin
      int_ff1_q <= INT;
      int_ff2_q <= int_ff1_q;
    end
  end

  // Main sequencer: wrt and vld default low so they pulse for one cycle;
  // every *_WAIT state retries its transaction if done never arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT_WAIT;
      tmr_q        <= '0;
      to_cnt_q     <= '0;
      idx_q        <= 2'd0;
      low_q        <= 8'h00;
      wrt_q        <= 1'b0;
      cmd_q        <= 16'h0000;
      setup_done_q <= 1'b0;
      yaw_q        <= 16'h0000;
      vld_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wrt_q <= 1'b0;
      vld_q <= 1'b0;
      case (state_q)
        INIT_WAIT: begin
          tmr_q <= tmr_d;
          if (&tmr_d) begin
            idx_q   <= 2'd0;
            state_q <= CFG_ISSUE;
          end
        end
        CFG_ISSUE: begin
          wrt_q    <= 1'b1;
          cmd_q    <= cfg_word(idx_q);
          to_cnt_q <= '0;
          state_q  <= CFG_WAIT;
        end
        CFG_WAIT: begin
          if (done) begin
            to_cnt_q <= '0;
            if (idx_q == 2'd2) begin
              setup_done_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= CFG_ISSUE;
            end
          end else if (to_expired_s) begin
            err_q    <= 1'b1;
            to_cnt_q <= '0;
            state_q  <= CFG_ISSUE;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end
        IDLE: begin
          if (int_ff2_q) begin
            state_q <= RDL_ISSUE;
          end
        end
        RDL_ISSUE: begin
          wrt_q    <= 1'b1;
          cmd_q    <= RD_YAWL;
          to_cnt_q <= '0;
          state_q  <= RDL_WAIT;
        end
        RDL_WAIT: begin
          if (done) begin
            to_cnt_q <= '0;
            low_q    <= rd_data[7:0];
            state_q  <= RDH_ISSUE;
          end else if (to_expired_s) begin
            err_q    <= 1'b1;
            to_cnt_q <= '0;
            state_q  <= RDL_ISSUE;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end
        RDH_ISSUE: begin
          wrt_q    <= 1'b1;
          cmd_q    <= RD_YAWH;
          to_cnt_q <= '0;
          state_q  <= RDH_WAIT;
        end
        RDH_WAIT: begin
          if (done) begin
            to_cnt_q <= '0;
            yaw_q    <= {rd_data[7:0], low_q};
            vld_q    <= 1'b1;
            state_q  <= IDLE;
          end else if (to_expired_s) begin
            err_q    <= 1'b1;
            to_cnt_q <= '0;
            state_q  <= RDH_ISSUE;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end
        default: begin
          state_q <= INIT_WAIT;
        end
      endcase
    end
  end

  assign wrt        = wrt_q;
  assign cmd        = cmd_q;
  assign setup_done = setup_done_q;
  assign yaw_rt     = yaw_q;
  assign vld        = vld_q;
  assign err        = err_q;

endmodule

// File: tb/tb_inert_spi_seq.sv
// Directed/randomized bench for inert_spi_seq with a behavioural sensor
// model: expected command order, yaw sample = {high byte, low byte}.
module tb_inert_spi_seq;

  localparam int TMR_W  = 8;
  localparam int TO_CYC = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic        setup_done;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_yaw;
  logic [15:0] cfg_exp [3] = '{16'h0D02, 16'h1160, 16'h1440};

  inert_spi_seq #(.TMR_W(TMR_W), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .setup_done(setup_done), .yaw_rt(yaw_rt),
    .vld(vld), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wrt"}, 32'(wrt), 32'd0);
    chk({tag, "_cmd"}, 32'(cmd), 32'h0000);
    chk({tag, "_setup_done"}, 32'(setup_done), 32'd0);
    chk({tag, "_yaw_rt"}, 32'(yaw_rt), 32'h0000);
    chk({tag, "_vld"}, 32'(vld), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Release reset and check the first wrt lands exactly 2^TMR_W cycles later
  task automatic powerup(input string tag, input bit stray_done);
    int early;
    early = 0;
    rst = 1'b0;
    if (stray_done) done = 1'b1;
    for (int k = 1; k <= (1 << TMR_W); k++) begin
      tick();
      done = 1'b0;
      if (k < (1 << TMR_W) && wrt !== 1'b0) early++;
    end
    chk({tag, "_no_early_wrt"}, 32'(early), 32'd0);
    chk({tag, "_first_wrt"}, 32'(wrt), 32'd1);
    chk({tag, "_first_cmd"}, 32'(cmd), 32'h0D02);
  endtask

  task automatic expect_wrt(input string tag, input logic [15:0] exp_cmd,
                            input int max_wait, output int waited);
    waited = 0;
    while (wrt !== 1'b1 && waited < max_wait) begin
      tick();
      waited++;
    end
    chk({tag, "_wrt_seen"}, 32'(wrt), 32'd1);
    chk({tag, "_cmd"}, 32'(cmd), 32'(exp_cmd));
  endtask

  // Sensor side of one transaction: stay quiet for lat cycles, then done
  task automatic respond(input string tag, input int lat, input logic [7:0] b);
    logic [15:0] c0;
    logic [7:0]  junk;
    int bad;
    c0  = cmd;
    bad = 0;
    for (int i = 0; i < lat; i++) begin
      tick();
      if (wrt !== 1'b0 || cmd !== c0) bad++;
    end
    chk({tag, "_quiet"}, 32'(bad), 32'd0);
    junk    = 8'($urandom_range(0, 255));
    done    = 1'b1;
    rd_data = {junk, b};
    tick();
    done    = 1'b0;
    rd_data = 16'($urandom);
  endtask

  task automatic do_config(input string tag);
    int w;
    respond({tag, "_c0"}, $urandom_range(3, 12), 8'h00);
    for (int i = 1; i < 3; i++) begin
      chk({tag, "_gap"}, 32'(wrt), 32'd0);
      expect_wrt({tag, "_c"}, cfg_exp[i], 4, w);
      chk({tag, "_not_yet_setup"}, 32'(setup_done), 32'd0);
      respond({tag, "_c"}, $urandom_range(3, 12), 8'h00);
    end
    chk({tag, "_setup_done"}, 32'(setup_done), 32'd1);
  endtask

  // One full yaw read; returns cycles waited for the first wrt
  task automatic do_read(input string tag, input bit hold_int, output int first_wait);
    logic [7:0] lo, hi;
    int w;
    lo  = 8'($urandom_range(0, 255));
    hi  = 8'($urandom_range(0, 255));
    INT = 1'b1;
    expect_wrt({tag, "_rdl"}, 16'hA600, 12, first_wait);
    if (!hold_int) INT = 1'b0;
    respond({tag, "_rdl"}, $urandom_range(3, 12), lo);
    chk({tag, "_no_partial"}, 32'(yaw_rt), 32'(exp_yaw));
    chk({tag, "_gap"}, 32'(wrt), 32'd0);
    expect_wrt({tag, "_rdh"}, 16'hA700, 4, w);
    respond({tag, "_rdh"}, $urandom_range(3, 12), hi);
    exp_yaw = {hi, lo};
    chk({tag, "_vld"}, 32'(vld), 32'd1);
    chk({tag, "_yaw"}, 32'(yaw_rt), 32'(exp_yaw));
    tick();
    chk({tag, "_vld_pulse"}, 32'(vld), 32'd0);
    chk({tag, "_yaw_hold"}, 32'(yaw_rt), 32'(exp_yaw));
  endtask

  task automatic chk_quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (wrt !== 1'b0 || vld !== 1'b0) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int w, n, early_err;
    logic [7:0] lo, hi;
    rst = 1'b1; INT = 1'b0; done = 1'b0; rd_data = 16'h0000;
    exp_yaw = 16'h0000;

    // 1. reset values and power-up wait
    tick(); tick();
    chk_reset_outputs("reset");
    powerup("pwr", 1'b0);

    // 2. configuration sequence
    do_config("cfg");
    chk_quiet("idle_no_int", 10);

    // done in a non-WAIT state is ignored
    done = 1'b1; tick(); done = 1'b0;
    chk_quiet("stray_done_idle", 5);
    chk("stray_done_setup", 32'(setup_done), 32'd1);

    // 3. yaw reads, fixed value then random values
    lo = 8'h34; hi = 8'h12;
    INT = 1'b1;
    expect_wrt("y1234_rdl", 16'hA600, 12, w);
    INT = 1'b0;
    respond("y1234_rdl", 5, lo);
    chk("y1234_gap", 32'(wrt), 32'd0);
    expect_wrt("y1234_rdh", 16'hA700, 4, w);
    respond("y1234_rdh", 7, hi);
    exp_yaw = 16'h1234;
    chk("y1234_vld", 32'(vld), 32'd1);
    chk("y1234_yaw", 32'(yaw_rt), 32'h1234);
    chk_quiet("y1234_single_vld", 10);
    for (int r = 0; r < 3; r++) begin
      do_read("rand_read", 1'b0, w);
      chk_quiet("rand_read_after", 6);
    end
    chk("no_err_yet", 32'(err), 32'd0);

    // 4. timeout on the high-byte read and retry
    lo = 8'($urandom_range(0, 255));
    hi = 8'($urandom_range(0, 255));
    INT = 1'b1;
    expect_wrt("to_rdl", 16'hA600, 12, w);
    INT = 1'b0;
    respond("to_rdl", 4, lo);
    expect_wrt("to_rdh", 16'hA700, 4, w);
    chk("to_err_before", 32'(err), 32'd0);
    n = 0; early_err = 0;
    do begin
      tick();
      n++;
      if (n < TO_CYC - 1 && err !== 1'b0) early_err++;
    end while (wrt !== 1'b1 && n < TO_CYC + 10);
    chk("to_err_early", 32'(early_err), 32'd0);
    chk("to_reissue_wrt", 32'(wrt), 32'd1);
    chk("to_reissue_cmd", 32'(cmd), 32'hA700);
    chk("to_err_set", 32'(err), 32'd1);
    chk("to_gap_window", 32'(n >= TO_CYC && n <= TO_CYC + 2), 32'd1);
    respond("to_rdh2", 6, hi);
    exp_yaw = {hi, lo};
    chk("to_vld", 32'(vld), 32'd1);
    chk("to_yaw", 32'(yaw_rt), 32'(exp_yaw));
    tick();
    chk("to_err_sticky", 32'(err), 32'd1);

    // 5. reset during RDH_WAIT, stray done, full setup again
    INT = 1'b1;
    expect_wrt("rst_rdl", 16'hA600, 12, w);
    INT = 1'b0;
    respond("rst_rdl", 4, 8'h5A);
    expect_wrt("rst_rdh", 16'hA700, 4, w);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    powerup("pwr2", 1'b1);
    chk("pwr2_yaw_clear", 32'(yaw_rt), 32'h0000);
    exp_yaw = 16'h0000;
    do_config("cfg2");

    // 6. INT held high: back-to-back reads with at most one idle cycle
    do_read("cont0", 1'b1, w);
    for (int r = 1; r < 4; r++) begin
      do_read("cont", r == 3 ? 1'b0 : 1'b1, w);
      chk("cont_idle_bound", 32'(w <= 1), 32'd1);
    end
    chk_quiet("cont_drain", 10);
    chk("cont_err_clear", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
